// File: rtl/fp96_round_arbiter_pkg.sv
// Shared fp96 rounding types: FP96/FP96N words, rounding-mode encodings and the
// in-flight slot record used by units that time-share the fp96 rounder.
package fp96_round_arbiter_pkg;

   localparam int FP96_W          = 96;
   localparam int FP96N_W         = 100;
   localparam int FP96_ROUND_LAT  = 3;
   localparam int FP96_RND_ID_W   = 3;   // holds a requester index for up to 8 requesters
   localparam int FP96_RND_TAG_W  = 16;  // widest tag any sharing unit may return

   typedef logic [FP96_W-1:0]  fp96_t;
   typedef logic [FP96N_W-1:0] fp96n_t;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RUP = 3'd2,
      RM_RDN = 3'd3,
      RM_RMM = 3'd4
   } fp96_rm_e;

   typedef struct packed {
      logic                      vld;
      logic [FP96_RND_ID_W-1:0]  id;
      logic [FP96_RND_TAG_W-1:0] tag;
   } fp96_rnd_slot_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_IDLE  = 2'd2
   } rnd_state_e;

endpackage

// File: rtl/fp96_round_arbiter_rr_arbiter.sv
// Round-robin grant over NREQ requesters; the pointer moves past the winner only
// when a grant is actually taken, so other shared FPU units can reuse it as-is.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_vld
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] idx;
   logic           found;

   // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
   always_comb begin
      found  = 1'b0;
      gnt_id = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            gnt_id = idx;
         end
      end
      gnt_vld = en & found;
      gnt     = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (gnt_vld)
         ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
   end

endmodule

// File: rtl/fp96_round_arbiter.sv
// Time-shares one fixed-latency fp96 rounder among NREQ post-normalisers, returns
// each result with its originator's tag, and offers a drain handshake.
module fp96_round_arbiter
   import fp96_round_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TAGW = 4,
   parameter int LAT  = FP96_ROUND_LAT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ce,
   input  logic [NREQ-1:0]               req_valid,
   output logic [NREQ-1:0]               req_ready,
   input  logic [NREQ-1:0][FP96N_W-1:0]  req_data,
   input  logic [NREQ-1:0][2:0]          req_rm,
   input  logic [NREQ-1:0][TAGW-1:0]     req_tag,
   output logic [FP96N_W-1:0]            rnd_i,
   output logic [2:0]                    rnd_rm,
   input  logic [FP96_W-1:0]             rnd_o,
   output logic [NREQ-1:0]               resp_valid,
   output logic [FP96_W-1:0]             resp_data,
   output logic [TAGW-1:0]               resp_tag,
   input  logic                          drain_req,
   output logic                          drained,
   output logic                          busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(LAT + 1);

   rnd_state_e                 state, state_nxt;
   fp96_rnd_slot_t [LAT-1:0]   sr;
   fp96_rnd_slot_t             slot_in, last;
   logic [CW-1:0]              cnt, cnt_nxt;
   logic [IDW-1:0]             gnt_id;
   logic                       issue, retire, arb_en;

   // Issuing stops the very cycle drain_req is seen, before the FSM leaves RUN.
   assign arb_en = ce & (state == ST_RUN) & ~drain_req;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (arb_en),
      .req     (req_valid),
      .gnt     (req_ready),
      .gnt_id  (gnt_id),
      .gnt_vld (issue)
   );

   always_comb begin
      slot_in = '0;
      rnd_i   = '0;
      rnd_rm  = '0;
      if (issue) begin
         slot_in.vld = 1'b1;
         slot_in.id  = FP96_RND_ID_W'(gnt_id);
         slot_in.tag = FP96_RND_TAG_W'(req_tag[gnt_id]);
         rnd_i       = req_data[gnt_id];
         rnd_rm      = req_rm[gnt_id];
      end
   end

   // NOTE: the slot pipe is reset so stale rounder contents are never reported as results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (ce) begin
         sr[0] <= slot_in;
         for (int i = 1; i < LAT; i++)
            sr[i] <= sr[i-1];
      end
   end

   assign last   = sr[LAT-1];
   assign retire = ce & last.vld;

   // Outputs are gated by the last-stage valid so they read zero whenever nothing returns.
   always_comb begin
      resp_valid = '0;
      resp_data  = '0;
      resp_tag   = '0;
      if (last.vld) begin
         resp_valid = NREQ'(1) << last.id;
         resp_data  = rnd_o;
         resp_tag   = TAGW'(last.tag);
      end
   end

   always_comb begin
      cnt_nxt = cnt;
      if (issue && !retire)
         cnt_nxt = cnt + CW'(1);
      else if (!issue && retire)
         cnt_nxt = cnt - CW'(1);
   end

   always_comb begin
      state_nxt = state;
      if (ce) begin
         unique case (state)
            ST_RUN:   if (drain_req) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
               if (cnt_nxt == '0)   state_nxt = ST_IDLE;
               else if (!drain_req) state_nxt = ST_RUN;
            end
            ST_IDLE:  if (!drain_req) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign busy    = (cnt != '0);
   assign drained = (state == ST_IDLE);

endmodule

// File: tb/tb_fp96_round_arbiter.sv
// Self-checking bench for fp96_round_arbiter: directed scenarios plus random traffic
// against a queue-based reference model and a behavioural rounder stub.
module tb_fp96_round_arbiter;

   localparam int NREQ = 4;
   localparam int TAGW = 4;
   localparam int LAT  = 3;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      ce = 1'b0;
   logic                      drain_req = 1'b0;
   logic [NREQ-1:0]           req_valid = '0;
   logic [NREQ-1:0]           req_ready;
   logic [NREQ-1:0][99:0]     req_data = '0;
   logic [NREQ-1:0][2:0]      req_rm = '0;
   logic [NREQ-1:0][TAGW-1:0] req_tag = '0;
   logic [99:0]               rnd_i;
   logic [2:0]                rnd_rm;
   logic [95:0]               rnd_o;
   logic [NREQ-1:0]           resp_valid;
   logic [95:0]               resp_data;
   logic [TAGW-1:0]           resp_tag;
   logic                      drained, busy;

   fp96_round_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_rm     (req_rm),
      .req_tag    (req_tag),
      .rnd_i      (rnd_i),
      .rnd_rm     (rnd_rm),
      .rnd_o      (rnd_o),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag),
      .drain_req  (drain_req),
      .drained    (drained),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Rounder stand-in: drops the 4 round bits and folds rm into the lsbs so rm routing is visible.
   function automatic logic [95:0] stub_round(input logic [99:0] i, input logic [2:0] rm);
      return {i[99:84], i[83:4]} ^ {93'd0, rm};
   endfunction

   logic [95:0] rpipe [LAT];
   always @(posedge clk) begin
      if (ce) begin
         rpipe[0] <= stub_round(rnd_i, rnd_rm);
         for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
      end
   end
   assign rnd_o = rpipe[LAT-1];

   typedef struct {
      logic [1:0]      id;
      logic [TAGW-1:0] tag;
      logic [99:0]     data;
      logic [2:0]      rm;
      int              due;
   } op_t;

   op_t        q[$];
   logic [1:0] m_ptr = '0;
   int         m_mode = 0;   // 0 accepting, 1 draining, 2 drained
   int         ce_cnt = 0;
   int         errors = 0;
   int         checks = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: compare against the model just after the negedge, then advance the model.
   task automatic step();
      bit              found, ret;
      logic [1:0]      gid, idx;
      logic [NREQ-1:0] e_ready, e_rv;
      logic [99:0]     e_rnd;
      logic [2:0]      e_rm;
      logic [95:0]     e_rd;
      logic [TAGW-1:0] e_rt;
      #1;
      found = 1'b0;
      gid   = '0;
      if (ce && m_mode == 0 && !drain_req) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = m_ptr + 2'(k);
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               gid   = idx;
            end
         end
      end
      e_ready = found ? (NREQ'(1) << gid) : '0;
      e_rnd   = found ? req_data[gid] : '0;
      e_rm    = found ? req_rm[gid] : '0;
      ret     = (q.size() > 0) && (q[0].due == ce_cnt);
      e_rv    = ret ? (NREQ'(1) << q[0].id) : '0;
      e_rd    = ret ? stub_round(q[0].data, q[0].rm) : '0;
      e_rt    = ret ? q[0].tag : '0;
      check("req_ready",  128'(req_ready),  128'(e_ready));
      check("rnd_i",      128'(rnd_i),      128'(e_rnd));
      check("rnd_rm",     128'(rnd_rm),     128'(e_rm));
      check("resp_valid", 128'(resp_valid), 128'(e_rv));
      check("resp_data",  128'(resp_data),  128'(e_rd));
      check("resp_tag",   128'(resp_tag),   128'(e_rt));
      check("busy",       128'(busy),       128'(q.size() != 0));
      check("drained",    128'(drained),    128'(m_mode == 2));
      if (ce) begin
         ce_cnt++;
         if (ret) void'(q.pop_front());
         if (found) begin
            q.push_back('{id: gid, tag: req_tag[gid], data: req_data[gid],
                          rm: req_rm[gid], due: ce_cnt - 1 + LAT});
            m_ptr = gid + 2'd1;
         end
         case (m_mode)
            0: if (drain_req) m_mode = 1;
            1: if (q.size() == 0) m_mode = 2; else if (!drain_req) m_mode = 0;
            default: if (!drain_req) m_mode = 0;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ready",  128'(req_ready),  128'(0));
      check("rst_rvalid", 128'(resp_valid), 128'(0));
      check("rst_rdata",  128'(resp_data),  128'(0));
      check("rst_rtag",   128'(resp_tag),   128'(0));
      check("rst_busy",   128'(busy),       128'(0));
      check("rst_drained",128'(drained),    128'(0));
      q.delete();
      m_ptr  = '0;
      m_mode = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_payload();
      logic [127:0] t;
      for (int i = 0; i < NREQ; i++) begin
         t = {$urandom, $urandom, $urandom, $urandom};
         req_data[i] = t[99:0];
         req_rm[i]   = 3'($urandom_range(0, 4));
         req_tag[i]  = TAGW'($urandom);
      end
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      // Reset values.
      @(negedge clk);
      #1;
      check("init_ready",  128'(req_ready),  128'(0));
      check("init_rvalid", 128'(resp_valid), 128'(0));
      check("init_busy",   128'(busy),       128'(0));
      check("init_drained",128'(drained),    128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // 1.0 from requester 0, RNE, tag 5.
      ce          = 1'b1;
      req_data[0] = {1'b0, 15'h3FFF, 80'h8000_0000_0000_0000_0000, 4'h0};
      req_rm[0]   = 3'd0;
      req_tag[0]  = 4'd5;
      req_valid   = 4'b0001;
      step();
      req_valid = '0;
      step();
      step();
      #1;
      check("one_rvalid", 128'(resp_valid), 128'(4'b0001));
      check("one_rdata",  128'(resp_data),  128'(96'h3FFF_8000_0000_0000_0000_0000));
      check("one_rtag",   128'(resp_tag),   128'(4'd5));
      step();
      idle(2);

      // All four valid for 8 cycles from ptr=0.
      do_reset();
      ce = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_payload();
         req_valid = 4'b1111;
         #1;
         check("rr_order", 128'(req_ready), 128'(4'b0001 << (i % 4)));
         step();
      end
      idle(5);

      // ce gap after one issue: result on the 3rd ce cycle counted from the issue.
      rand_payload();
      req_valid = 4'b0010;
      step();
      ce = 1'b0;
      req_valid = 4'b1111;
      step();
      step();
      ce = 1'b1;
      req_valid = '0;
      step();
      step();
      #1;
      check("ce_rvalid", 128'(resp_valid), 128'(4'b0010));
      check("ce_rtag",   128'(resp_tag),   128'(req_tag[1]));
      step();
      idle(3);

      // Drain with three ops in flight.
      rand_payload();
      req_valid = 4'b0111;
      step();
      step();
      step();
      drain_req = 1'b1;
      req_valid = 4'b1111;
      step();
      step();
      step();
      #1;
      check("drain_done", 128'(drained), 128'(1));
      check("drain_busy", 128'(busy),    128'(0));
      step();
      drain_req = 1'b0;
      step();
      step();
      step();
      idle(4);

      // Wrap: grant 2 twice so ptr sits at 3, then 2 alone wins again, then 3 wins.
      rand_payload();
      req_valid = 4'b0100;
      step();
      #1;
      check("wrap_gnt2", 128'(req_ready), 128'(4'b0100));
      step();
      req_valid = 4'b1100;
      #1;
      check("wrap_ptr3", 128'(req_ready), 128'(4'b1000));
      step();
      idle(4);

      // Reset with two ops in flight: nothing returns afterwards.
      rand_payload();
      req_valid = 4'b0011;
      step();
      step();
      do_reset();
      ce = 1'b1;
      idle(5);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         rand_payload();
         ce        = ($urandom_range(0, 3) != 0);
         req_valid = NREQ'($urandom);
         if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
         if (n == 200) begin
            do_reset();
            req_valid = NREQ'($urandom);
         end
         step();
      end
      drain_req = 1'b0;
      ce = 1'b1;
      idle(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp96_round_arbiter.md
Name: fp96_round_arbiter

Overview:
- Shares one fp96 rounding unit among NREQ requesters (add, mul, div, fma post-normalisers).
- The rounding unit takes an FP96N intermediate plus a 3-bit rm and returns an FP96 result after a fixed 3 ce-qualified clocks.
- This block picks one requester per issue slot (round-robin), drives the rounder, and tracks in-flight ops in a shift register. Each result returns to its originator with the originator's tag.
- Provides a drain/quiesce handshake so the FPU sequencer can empty the rounder before a mode change or context switch.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 4, width of per-op requester tag, returned unchanged.
- LAT, 3, rounder latency in ce-qualified clocks; must match the rounder build (1 when built MIN_LATENCY).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable, shared with the rounder; nothing advances when low.
- req_valid  in  NREQ  per-requester op valid.
- req_ready  out  NREQ  per-requester grant (one-hot or zero).
- req_data  in  NREQ x 100  per-requester FP96N intermediate.
- req_rm  in  NREQ x 3  per-requester rounding mode.
- req_tag  in  NREQ x TAGW  per-requester tag.
- rnd_i  out  100  to rounder i.
- rnd_rm  out  3  to rounder rm.
- rnd_o  in  96  from rounder o (FP96).
- resp_valid  out  NREQ  one-hot result-valid pulse.
- resp_data  out  96  rounded result, shared bus.
- resp_tag  out  TAGW  tag of returning op.
- drain_req  in  1  level; stop accepting new ops.
- drained  out  1  high when draining and pipeline empty.
- busy  out  1  any op in flight.

Behaviour:
- Issue:
  - An issue occurs on a clk edge with ce=1, FSM in RUN, and at least one req_valid.
  - req_ready is combinational, one-hot, and only asserted under those conditions. The handshake is req_valid & req_ready on the same ce cycle.
  - rnd_i and rnd_rm are combinational muxes of the granted requester's data. When there is no grant they are driven with all-zero data and rm=0, and the slot is marked empty.
- Arbitration:
  - Round-robin pointer ptr (log2 NREQ bits, reset 0).
  - Grant goes to the first valid requester at or after ptr, wrapping modulo NREQ.
  - On an issue, ptr becomes granted+1 mod NREQ. With no issue, ptr holds.
- Tracking:
  - A LAT-deep shift register of {vld, id, tag} shifts only when ce=1. Stage 0 loads {issue, grant id, req_tag}.
  - When the last stage holds vld=1, resp_valid[id] pulses for exactly that cycle. resp_data=rnd_o and resp_tag=tag.
  - Results carry no backpressure; requesters must accept.
  - With ce=0: shift register, ptr and FSM all hold, resp_valid holds its value, and req_ready is all zero.
- Occupancy:
  - cnt (0..LAT) increments on issue, decrements on retire, and is unchanged when both happen in one cycle.
  - busy = (cnt != 0).
- FSM (reset RUN):
  - RUN -> DRAIN when drain_req=1 (sampled with ce). No issue occurs in the cycle drain_req is first seen high.
  - DRAIN -> IDLE when cnt=0, or in the same cycle the last retire brings cnt to 0.
  - DRAIN -> RUN if drain_req drops before empty; in-flight ops still retire normally.
  - IDLE -> RUN when drain_req=0.
  - drained = (state==IDLE).
- Simultaneous events: issue and retire in the same cycle are both honoured.
- Reset:
  - Asynchronous clear of all state. In-flight ops are discarded with no resp_valid.
  - Outputs at reset: req_ready=0, resp_valid=0, resp_data=0, resp_tag=0, busy=0, drained=0.
  - The rounder's own internal pipeline contents are ignored because all vld bits are cleared.

Decomposition:
- fp96Pkg supplies FP96, FP96N and rm encodings (0 RNE, 1 RTZ, 2 RUP, 3 RDN, 4 RMM).
- Add to fp96Pkg: typedef fp96_rnd_slot_t {vld, id, tag} and constant FP96_ROUND_LAT=3.
- One sub-module: rr_arbiter (NREQ-wide round-robin grant with pointer update), reusable by other shared FPU units.

Test Plan:
- Single requester 0 issues FP96N of 1.0 with RNE, tag 5 -> resp_valid[0] exactly LAT ce-cycles later, resp_data=96'h3FFF_8000_0000_0000_0000_0000 per package encoding, resp_tag=5.
- All 4 requesters valid continuously for 8 cycles from ptr=0 -> grants in order 0,1,2,3,0,1,2,3, and responses return in the same order with matching tags.
- ce toggled 1,0,0,1,1,1 after one issue -> result appears on the 3rd ce=1 cycle after issue, and no grants occur while ce=0.
- drain_req raised with 3 ops in flight -> no further grants, busy=1 for 3 cycles, then drained=1. Dropping drain_req -> RUN, and grants resume next cycle.
- Assert rst_n low with 2 ops in flight -> immediate zero outputs, and no resp_valid after release.
- Requester 2 alone valid at ptr=3 -> grant 2 (wrap), ptr becomes 3.
